// File: rtl/hqm_sberep_pkg.sv
// rtl/hqm_sberep_pkg.sv - shared entry type, channel indices and pointer helper for the sideband master repeater
`ifndef HQM_SBEREP_ENTRY_T
`define HQM_SBEREP_ENTRY_T(W) struct packed { logic eom; logic parity; logic [(W)-1:0] payload; }
`endif

package hqm_sberep_pkg;

    localparam int PC = 0;
    localparam int NP = 1;

    // Index width; callers add one more bit for the wrap flag.
    function automatic int ptr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/hqm_sberep_fifo.sv
// rtl/hqm_sberep_fifo.sv - single-clock FIFO with wrap-bit pointers, any DEPTH >= 2
module hqm_sberep_fifo
    import hqm_sberep_pkg::*;
#(
    parameter int WIDTH = 34,
    parameter int DEPTH = 2,
    localparam int PW = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [PW:0]      wptr,
    output logic [PW:0]      wptr_next,
    output logic [PW:0]      rptr,
    output logic [PW:0]      occ,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             push_ok;
    logic             pop_ok;
    logic [PW:0]      rptr_next;
    logic [PW:0]      occ_next;

    // Index wraps at DEPTH-1 rather than at a power of two; the top bit flips on each wrap.
    function automatic logic [PW:0] ptr_inc(input logic [PW:0] p);
        if (p[PW-1:0] == PW'(DEPTH - 1)) begin
            return {~p[PW], {PW{1'b0}}};
        end
        return p + (PW + 1)'(1);
    endfunction

    assign push_ok   = push & ~full;
    assign pop_ok    = pop & ~empty;
    assign wptr_next = push_ok ? ptr_inc(wptr) : wptr;
    assign rptr_next = pop_ok ? ptr_inc(rptr) : rptr;
    assign rdata     = empty ? '0 : mem[rptr[PW-1:0]];

    always_comb begin
        occ_next = occ;
        if (push_ok && !pop_ok) begin
            occ_next = occ + (PW + 1)'(1);
        end else if (pop_ok && !push_ok) begin
            occ_next = occ - (PW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            occ   <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            wptr  <= wptr_next;
            rptr  <= rptr_next;
            occ   <= occ_next;
            full  <= (occ_next == (PW + 1)'(DEPTH));
            empty <= (occ_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr[PW-1:0]] <= wdata;
        end
    end

`ifndef SYNTHESIS
    a_pop_empty: assert property (@(posedge clk) disable iff (rst) !(pop && empty));
    a_occ_range: assert property (@(posedge clk) disable iff (rst) occ <= (PW + 1)'(DEPTH));
`endif

endmodule

// File: rtl/hqm_sberep_mst_gen.sv
// rtl/hqm_sberep_mst_gen.sv - master-side sideband repeater: PC/NP FIFOs, NP-behind-PC fence, parity check
module hqm_sberep_mst_gen
    import hqm_sberep_pkg::*;
#(
    parameter int PLD_W    = 32,
    parameter int DEPTH    = 2,
    parameter bit FENCE_EN = 1'b1,
    parameter bit PAR_CHK  = 1'b1,
    localparam int PW = ptr_w(DEPTH)
) (
    input  logic             agent_clk,
    input  logic             agent_rst,
    input  logic             ip_pc_irdy,
    input  logic             ip_np_irdy,
    input  logic             ip_pc_eom,
    input  logic             ip_np_eom,
    input  logic             ip_pc_parity,
    input  logic             ip_np_parity,
    input  logic [PLD_W-1:0] ip_pc_payload,
    input  logic [PLD_W-1:0] ip_np_payload,
    output logic             ip_pc_trdy,
    output logic             ip_np_trdy,
    output logic             ep_pc_irdy,
    output logic             ep_np_irdy,
    output logic             ep_pc_eom,
    output logic             ep_np_eom,
    output logic             ep_pc_parity,
    output logic             ep_np_parity,
    output logic [PLD_W-1:0] ep_pc_payload,
    output logic [PLD_W-1:0] ep_np_payload,
    input  logic             ep_pc_trdy,
    input  logic             ep_np_trdy,
    input  logic             ep_pc_sel,
    input  logic             ep_np_sel,
    output logic [PW:0]      occ_pc,
    output logic [PW:0]      occ_np,
    output logic [1:0]       full,
    output logic [1:0]       empty,
    output logic [1:0]       par_err
);

    typedef `HQM_SBEREP_ENTRY_T(PLD_W) entry_t;

    localparam int EW  = $bits(entry_t);
    localparam int PCW = EW + PW + 1;

    entry_t          pc_in;
    entry_t          np_in;
    entry_t          pc_head;
    entry_t          np_head;
    logic [PCW-1:0]  pc_rdata;
    logic [PW:0]     pc_tag;
    logic [PW:0]     pc_wptr;
    logic [PW:0]     pc_wptr_next;
    logic [PW:0]     pc_rptr;
    logic [PW:0]     np_wptr;
    logic [PW:0]     np_wptr_next;
    logic [PW:0]     np_rptr;
    logic            pc_push;
    logic            np_push;
    logic            pc_pop;
    logic            np_pop;

    assign pc_in      = '{eom: ip_pc_eom, parity: ip_pc_parity, payload: ip_pc_payload};
    assign np_in      = '{eom: ip_np_eom, parity: ip_np_parity, payload: ip_np_payload};
    assign ip_pc_trdy = ~full[PC];
    assign ip_np_trdy = ~full[NP];
    assign pc_push    = ip_pc_irdy & ip_pc_trdy;
    assign np_push    = ip_np_irdy & ip_np_trdy;
    assign pc_pop     = ep_pc_trdy & ep_pc_sel & ep_pc_irdy;
    assign np_pop     = ep_np_trdy & ep_np_sel & ep_np_irdy;

    // Tag is the NP write pointer after this cycle's NP push, so a same-cycle NP flit counts as older.
    hqm_sberep_fifo #(.WIDTH(PCW), .DEPTH(DEPTH)) u_pc_fifo (
        .clk       (agent_clk),
        .rst       (agent_rst),
        .push      (pc_push),
        .pop       (pc_pop),
        .wdata     ({np_wptr_next, pc_in}),
        .rdata     (pc_rdata),
        .wptr      (pc_wptr),
        .wptr_next (pc_wptr_next),
        .rptr      (pc_rptr),
        .occ       (occ_pc),
        .full      (full[PC]),
        .empty     (empty[PC])
    );

    hqm_sberep_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_np_fifo (
        .clk       (agent_clk),
        .rst       (agent_rst),
        .push      (np_push),
        .pop       (np_pop),
        .wdata     (np_in),
        .rdata     (np_head),
        .wptr      (np_wptr),
        .wptr_next (np_wptr_next),
        .rptr      (np_rptr),
        .occ       (occ_np),
        .full      (full[NP]),
        .empty     (empty[NP])
    );

    assign pc_tag  = pc_rdata[EW +: PW + 1];
    assign pc_head = pc_rdata[EW-1:0];

    assign ep_pc_irdy    = ~empty[PC];
    assign ep_pc_eom     = pc_head.eom;
    assign ep_pc_parity  = pc_head.parity;
    assign ep_pc_payload = pc_head.payload;
    assign ep_np_eom     = np_head.eom;
    assign ep_np_parity  = np_head.parity;
    assign ep_np_payload = np_head.payload;

    // NP head is blocked when the oldest PC flit was pushed before it, i.e. its tag equals the NP read pointer.
    if (FENCE_EN) begin : g_fence
        assign ep_np_irdy = ~empty[NP] & (empty[PC] | (pc_tag != np_rptr));
`ifndef SYNTHESIS
        a_np_fence: assert property (@(posedge agent_clk) disable iff (agent_rst)
            !(ep_np_irdy && !empty[PC] && (pc_tag == np_rptr)));
`endif
    end else begin : g_no_fence
        assign ep_np_irdy = ~empty[NP];
    end

    always_ff @(posedge agent_clk) begin
        if (agent_rst) begin
            par_err <= 2'b00;
        end else begin
            if (PAR_CHK && pc_push && (^pc_in)) begin
                par_err[PC] <= 1'b1;
            end
            if (PAR_CHK && np_push && (^np_in)) begin
                par_err[NP] <= 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    a_pc_idle: assert property (@(posedge agent_clk) disable iff (agent_rst)
        !pc_push |-> (pc_wptr_next == pc_wptr));
    a_pc_empty_ptr: assert property (@(posedge agent_clk) disable iff (agent_rst)
        empty[PC] |-> (pc_wptr == pc_rptr));
    a_np_empty_ptr: assert property (@(posedge agent_clk) disable iff (agent_rst)
        empty[NP] |-> (np_wptr == np_rptr));
`endif

endmodule

// File: tb/tb_hqm_sberep_mst_gen.sv
// tb/tb_hqm_sberep_mst_gen.sv - directed scoreboard bench for the sideband master repeater
module tb_hqm_sberep_mst_gen;

    localparam int PLD_W = 32;
    localparam int DEPTH = 3;
    localparam int PW    = $clog2(DEPTH);

    logic agent_clk = 1'b0;
    always #5 agent_clk = ~agent_clk;

    logic             agent_rst;
    logic             ip_pc_irdy, ip_np_irdy, ip_pc_eom, ip_np_eom, ip_pc_parity, ip_np_parity;
    logic [PLD_W-1:0] ip_pc_payload, ip_np_payload;
    logic             ep_pc_trdy, ep_np_trdy, ep_pc_sel, ep_np_sel;

    logic             ip_pc_trdy, ip_np_trdy, ep_pc_irdy, ep_np_irdy;
    logic             ep_pc_eom, ep_np_eom, ep_pc_parity, ep_np_parity;
    logic [PLD_W-1:0] ep_pc_payload, ep_np_payload;
    logic [PW:0]      occ_pc, occ_np;
    logic [1:0]       full, empty, par_err;

    logic             b_ip_pc_trdy, b_ip_np_trdy, b_ep_pc_irdy, b_ep_np_irdy;
    logic             b_ep_pc_eom, b_ep_np_eom, b_ep_pc_parity, b_ep_np_parity;
    logic [PLD_W-1:0] b_ep_pc_payload, b_ep_np_payload;
    logic [PW:0]      b_occ_pc, b_occ_np;
    logic [1:0]       b_full, b_empty, b_par_err;

    int tests = 0;
    int fails = 0;
    logic [PLD_W+1:0] pc_q[$];
    logic [PLD_W+1:0] np_q[$];

    hqm_sberep_mst_gen #(.PLD_W(PLD_W), .DEPTH(DEPTH), .FENCE_EN(1'b1), .PAR_CHK(1'b1)) u_dut (
        .agent_clk(agent_clk), .agent_rst(agent_rst),
        .ip_pc_irdy(ip_pc_irdy), .ip_np_irdy(ip_np_irdy),
        .ip_pc_eom(ip_pc_eom), .ip_np_eom(ip_np_eom),
        .ip_pc_parity(ip_pc_parity), .ip_np_parity(ip_np_parity),
        .ip_pc_payload(ip_pc_payload), .ip_np_payload(ip_np_payload),
        .ip_pc_trdy(ip_pc_trdy), .ip_np_trdy(ip_np_trdy),
        .ep_pc_irdy(ep_pc_irdy), .ep_np_irdy(ep_np_irdy),
        .ep_pc_eom(ep_pc_eom), .ep_np_eom(ep_np_eom),
        .ep_pc_parity(ep_pc_parity), .ep_np_parity(ep_np_parity),
        .ep_pc_payload(ep_pc_payload), .ep_np_payload(ep_np_payload),
        .ep_pc_trdy(ep_pc_trdy), .ep_np_trdy(ep_np_trdy),
        .ep_pc_sel(ep_pc_sel), .ep_np_sel(ep_np_sel),
        .occ_pc(occ_pc), .occ_np(occ_np),
        .full(full), .empty(empty), .par_err(par_err)
    );

    hqm_sberep_mst_gen #(.PLD_W(PLD_W), .DEPTH(DEPTH), .FENCE_EN(1'b0), .PAR_CHK(1'b1)) u_dut_nofence (
        .agent_clk(agent_clk), .agent_rst(agent_rst),
        .ip_pc_irdy(ip_pc_irdy), .ip_np_irdy(ip_np_irdy),
        .ip_pc_eom(ip_pc_eom), .ip_np_eom(ip_np_eom),
        .ip_pc_parity(ip_pc_parity), .ip_np_parity(ip_np_parity),
        .ip_pc_payload(ip_pc_payload), .ip_np_payload(ip_np_payload),
        .ip_pc_trdy(b_ip_pc_trdy), .ip_np_trdy(b_ip_np_trdy),
        .ep_pc_irdy(b_ep_pc_irdy), .ep_np_irdy(b_ep_np_irdy),
        .ep_pc_eom(b_ep_pc_eom), .ep_np_eom(b_ep_np_eom),
        .ep_pc_parity(b_ep_pc_parity), .ep_np_parity(b_ep_np_parity),
        .ep_pc_payload(b_ep_pc_payload), .ep_np_payload(b_ep_np_payload),
        .ep_pc_trdy(ep_pc_trdy), .ep_np_trdy(ep_np_trdy),
        .ep_pc_sel(ep_pc_sel), .ep_np_sel(ep_np_sel),
        .occ_pc(b_occ_pc), .occ_np(b_occ_np),
        .full(b_full), .empty(b_empty), .par_err(b_par_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks pops against the scoreboard and records accepted pushes, then advances one clock.
    task automatic tick();
        logic [PLD_W+1:0] e;
        #1;
        if (!agent_rst) begin
            if (ep_pc_irdy && ep_pc_trdy && ep_pc_sel) begin
                chk("pc_sb_nonempty", 64'(pc_q.size() != 0), 1);
                if (pc_q.size() != 0) begin
                    e = pc_q.pop_front();
                    chk("pc_sb_data", {ep_pc_eom, ep_pc_parity, ep_pc_payload}, e);
                end
            end
            if (ep_np_irdy && ep_np_trdy && ep_np_sel) begin
                chk("np_sb_nonempty", 64'(np_q.size() != 0), 1);
                if (np_q.size() != 0) begin
                    e = np_q.pop_front();
                    chk("np_sb_data", {ep_np_eom, ep_np_parity, ep_np_payload}, e);
                end
            end
            if (ip_pc_irdy && ip_pc_trdy) pc_q.push_back({ip_pc_eom, ip_pc_parity, ip_pc_payload});
            if (ip_np_irdy && ip_np_trdy) np_q.push_back({ip_np_eom, ip_np_parity, ip_np_payload});
        end
        @(posedge agent_clk);
        #1;
        if (agent_rst) begin
            pc_q.delete();
            np_q.delete();
        end
    endtask

    task automatic set_pc(input logic v, input logic [PLD_W-1:0] d, input logic eom);
        ip_pc_irdy = v; ip_pc_payload = d; ip_pc_eom = eom; ip_pc_parity = ^{d, eom};
    endtask

    task automatic set_np(input logic v, input logic [PLD_W-1:0] d, input logic eom);
        ip_np_irdy = v; ip_np_payload = d; ip_np_eom = eom; ip_np_parity = ^{d, eom};
    endtask

    initial begin
        agent_rst = 1'b1;
        set_pc(0, '0, 0);
        set_np(0, '0, 0);
        ep_pc_trdy = 0; ep_np_trdy = 0; ep_pc_sel = 1; ep_np_sel = 1;
        tick();
        tick();
        agent_rst = 1'b0;
        chk("rst_empty", empty, 2'b11);
        chk("rst_full", full, 2'b00);
        chk("rst_par_err", par_err, 2'b00);
        chk("rst_ep_pc_irdy", ep_pc_irdy, 0);
        chk("rst_ep_np_irdy", ep_np_irdy, 0);
        chk("rst_ep_pc_payload", ep_pc_payload, 0);
        chk("rst_trdy", {ip_np_trdy, ip_pc_trdy}, 2'b11);
        chk("rst_occ", {occ_np, occ_pc}, 0);

        // Single PC flit: visible the cycle after push, data zeroed once popped.
        set_pc(1, 32'hA5A5_0001, 1);
        tick();
        set_pc(0, '0, 0);
        chk("one_irdy", ep_pc_irdy, 1);
        chk("one_payload", ep_pc_payload, 32'hA5A5_0001);
        chk("one_eom_par", {ep_pc_eom, ep_pc_parity}, 2'b10);
        chk("one_occ", occ_pc, 1);
        ep_pc_trdy = 1;
        tick();
        ep_pc_trdy = 0;
        chk("one_pop_empty", empty[0], 1);
        chk("one_pop_payload", ep_pc_payload, 0);
        chk("one_pop_occ", occ_pc, 0);

        // Fill to DEPTH, then pop while full: trdy stays low that cycle.
        for (int i = 0; i < 3; i++) begin
            set_pc(1, 32'h3000_0000 + i, (i == 2));
            tick();
        end
        chk("fill_trdy", ip_pc_trdy, 0);
        chk("fill_occ", occ_pc, 3);
        chk("fill_full", full, 2'b01);
        set_pc(1, 32'h3000_0003, 0);
        ep_pc_trdy = 1;
        #1;
        chk("full_pop_trdy_low", ip_pc_trdy, 0);
        tick();
        chk("full_pop_occ", occ_pc, 2);
        chk("full_pop_trdy", ip_pc_trdy, 1);
        for (int i = 0; i < 10; i++) begin
            set_pc(1, 32'h4000_0000 + i, i[0]);
            tick();
        end
        set_pc(0, '0, 0);
        for (int n = 0; n < 8 && !empty[0]; n++) tick();
        ep_pc_trdy = 0;
        chk("stream_drained_empty", empty[0], 1);
        chk("stream_sb_drained", pc_q.size(), 0);
        chk("stream_occ", occ_pc, 0);

        // Fence: NP behind stalled older PC.
        set_pc(1, 32'h5000_0000, 1);
        tick();
        set_pc(0, '0, 0);
        set_np(1, 32'h6000_0000, 1);
        tick();
        set_np(0, '0, 0);
        chk("fence_block", ep_np_irdy, 0);
        chk("nofence_flow", b_ep_np_irdy, 1);
        chk("nofence_payload", b_ep_np_payload, 32'h6000_0000);
        tick();
        chk("fence_hold", ep_np_irdy, 0);
        ep_pc_trdy = 1;
        tick();
        ep_pc_trdy = 0;
        chk("fence_release", ep_np_irdy, 1);
        chk("fence_release_empty", empty, 2'b01);
        ep_np_trdy = 1;
        tick();
        ep_np_trdy = 0;
        chk("fence_done_empty", empty, 2'b11);

        // Same-cycle PC and NP push: NP counts as older.
        ep_pc_trdy = 1; ep_np_trdy = 1;
        set_pc(1, 32'h7000_0000, 1);
        set_np(1, 32'h7100_0000, 1);
        tick();
        set_pc(0, '0, 0);
        set_np(0, '0, 0);
        chk("same_cycle_np_irdy", ep_np_irdy, 1);
        chk("same_cycle_pc_irdy", ep_pc_irdy, 1);
        tick();
        ep_pc_trdy = 0; ep_np_trdy = 0;
        chk("same_cycle_empty", empty, 2'b11);

        // N0, P1, N1 with PC stalled: N0 passes, N1 waits for P1.
        set_np(1, 32'h8100_0000, 1); tick(); set_np(0, '0, 0);
        set_pc(1, 32'h8000_0000, 1); tick(); set_pc(0, '0, 0);
        set_np(1, 32'h8100_0001, 0); tick(); set_np(0, '0, 0);
        chk("older_np_irdy", ep_np_irdy, 1);
        ep_np_trdy = 1;
        tick();
        ep_np_trdy = 0;
        chk("younger_np_fenced", ep_np_irdy, 0);
        chk("younger_np_occ", occ_np, 1);
        ep_pc_trdy = 1;
        tick();
        ep_pc_trdy = 0;
        chk("younger_np_release", ep_np_irdy, 1);
        ep_np_trdy = 1;
        tick();
        ep_np_trdy = 0;
        chk("mixed_empty", empty, 2'b11);

        // Odd-parity NP flit: flagged, still forwarded unchanged.
        ip_np_irdy = 1; ip_np_payload = 32'h0000_0001; ip_np_eom = 0; ip_np_parity = 0;
        tick();
        set_np(0, '0, 0);
        chk("par_err_set", par_err, 2'b10);
        chk("par_fwd_payload", ep_np_payload, 32'h0000_0001);
        ep_np_trdy = 1;
        tick();
        ep_np_trdy = 0;
        tick();
        chk("par_err_sticky", par_err, 2'b10);

        // Reset mid-stream discards everything.
        set_pc(1, 32'h9000_0000, 0); tick();
        set_pc(1, 32'h9000_0001, 1); set_np(1, 32'h9100_0000, 1); tick();
        set_pc(0, '0, 0); set_np(0, '0, 0);
        chk("pre_rst_occ", occ_pc, 2);
        agent_rst = 1'b1;
        tick();
        agent_rst = 1'b0;
        chk("mid_rst_par_err", par_err, 2'b00);
        chk("mid_rst_occ", {occ_np, occ_pc}, 0);
        chk("mid_rst_irdy", {ep_np_irdy, ep_pc_irdy}, 2'b00);
        chk("mid_rst_payload", {ep_np_payload, ep_pc_payload}, 0);
        chk("mid_rst_empty", empty, 2'b11);
        set_pc(1, 32'hA000_0001, 1);
        tick();
        set_pc(0, '0, 0);
        ep_pc_trdy = 1;
        tick();
        ep_pc_trdy = 0;
        chk("end_pc_sb", pc_q.size(), 0);
        chk("end_np_sb", np_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hqm_sberep_mst_gen.md
Name: hqm_sberep_mst_gen

Overview:
- Parametrised master-side sideband repeater between the agent and the sideband endpoint: one FIFO each for posted/completion (PC) and non-posted (NP) traffic.
- Parametrised in payload width, FIFO depth and NP-ordering mode.
- Adds an agent-side trdy handshake, occupancy outputs and a sticky parity-error flag.
- Enforces that an NP flit is never presented ahead of an older PC flit.

Parameters:
- PLD_W, 32: payload width in bits.
- DEPTH, 2: entries per channel FIFO; any integer >=2, not restricted to powers of 2.
- FENCE_EN, 1: 1 = NP ordered behind older PC; 0 = channels fully independent.
- PAR_CHK, 1: 1 = check even parity on push.
- Derived PW = $clog2(DEPTH); pointers are PW+1 bits (extra wrap bit).

Ports:
- agent_clk  in  1  clock
- agent_rst  in  1  synchronous active-high reset
- ip_pc_irdy, ip_np_irdy  in  1  agent flit valid
- ip_pc_eom, ip_np_eom  in  1  end of message
- ip_pc_parity, ip_np_parity  in  1  flit parity
- ip_pc_payload, ip_np_payload  in  PLD_W  flit data
- ip_pc_trdy, ip_np_trdy  out  1  FIFO not full
- ep_pc_irdy, ep_np_irdy  out  1  head valid (NP gated by fence)
- ep_pc_eom, ep_np_eom, ep_pc_parity, ep_np_parity  out  1  head fields
- ep_pc_payload, ep_np_payload  out  PLD_W  head payload
- ep_pc_trdy, ep_np_trdy  in  1  endpoint accept
- ep_pc_sel, ep_np_sel  in  1  endpoint channel select
- occ_pc, occ_np  out  PW+1  entries held, 0..DEPTH
- full, empty  out  2  [0]=PC, [1]=NP
- par_err  out  2  sticky parity error, [0]=PC, [1]=NP

Behaviour:
- Reset (synchronous, agent_rst=1 at posedge):
  - pointers and occupancy cleared; empty=2'b11, full=0, par_err=0;
  - all ep_* outputs 0; ip_*_trdy=1.
  - Reset mid-message discards all entries; no flush handshake.
- Push per channel = ip_irdy & ip_trdy, with ip_trdy = !full.
  - Entry = {eom, parity, payload}.
  - PC entry additionally stores tag = NP write pointer after any same-cycle NP push, so a simultaneous NP push counts as older than the PC flit.
- Pop per channel = ep_trdy & ep_sel & ep_irdy. Pop while empty is ignored; the assertion fires.
- Latency: a pushed flit is visible on ep_* the next cycle (registered storage, no bypass).
  - Push while full is impossible because trdy is low.
  - Push and pop in the same cycle when full: trdy is still low that cycle (no pass-through).
- ep_* data fields are 0 when empty. They must not be driven from stale memory.
- Pointer wrap: the index runs 0..DEPTH-1, then returns to 0 with the wrap bit toggled. This holds for non-power-of-2 DEPTH.
- Occupancy:
  - occ = +1 on push only, -1 on pop only, unchanged on both or neither.
  - full = (occ==DEPTH); empty = (occ==0); both registered.
- NP fence, FENCE_EN=1: ep_np_irdy = !empty[1] & (empty[0] | pc_head_tag != np_rptr).
  - Comparison uses the full PW+1-bit pointer. This is correct because the NP FIFO cannot run more than DEPTH ahead of the PC head tag.
  - With FENCE_EN=0, ep_np_irdy = !empty[1].
- PC is never fenced.
- Parity check, PAR_CHK=1:
  - On push, ^{payload, eom, parity} must be 0; otherwise set par_err[ch].
  - The flit is still stored and forwarded unchanged.
  - par_err clears only on reset.
- Assertions (sim only):
  - pop when empty;
  - ep_np_irdy high while an older PC flit is pending;
  - occ > DEPTH.

Decomposition:
- Package hqm_sberep_pkg: typedef of the entry struct (eom, parity, payload, parameterised by PLD_W via a parameterised-struct idiom or macro), pointer-width function, and channel index constants PC=0, NP=1.
- Sub-module hqm_sberep_fifo: single-clock FIFO with parameters WIDTH and DEPTH.
  - Outputs: wptr, wptr_next, rptr, occ, full, empty.
  - Instantiated twice; the PC instance has WIDTH widened by PW+1 for the tag.
- Fence and parity logic live in the top.

Test Plan:
- Reset, then 1 PC flit payload 0xA5A5_0001, eom=1, parity=0 -> ep_pc_irdy=1 the next cycle, payload 0xA5A5_0001, occ_pc=1; pop -> empty[0]=1, ep_pc_payload=0.
- DEPTH=3: push 3 PC flits with no pop -> ip_pc_trdy=0, occ_pc=3.
  - Continuous push/pop for 10 flits -> data order preserved across the wrap, no loss.
- FENCE_EN=1: PC flit P0 (ep_pc_trdy held 0), then NP flit N0 -> ep_np_irdy=0 until P0 pops, then 1 in the same cycle P0 leaves.
- Same-cycle PC push and NP push with both ep_trdy=1 -> ep_np_irdy=1 immediately (NP treated as older).
  - Repeat with FENCE_EN=0 and a PC stall -> NP flows regardless.
- Push NP payload 0x0000_0001, eom=0, parity=0 (odd) -> par_err=2'b10 and stays set; the flit is still forwarded.
  - Assert agent_rst mid-stream -> par_err=0, occ=0, ep_* = 0 the next cycle.
